csr_file: RTL and testbench

Machine-mode control/status register file for the RV32 core, sitting beside the execute stage. Performs CSR read-modify-write (write/set/clear), latches interrupt-pending lines, and sequences trap entry and `mret` return, producing the redirect PC. Parametrised successor of the original four-entry CSR store: it adds `mtvec`, `mcause`, a 64-bit `mcycle` counter, vectored interrupt mode and illegal-access detection.

---
 rtl/csr_pkg.sv | 41 ++++
 rtl/csr_file_if.sv | 16 +
 rtl/csr_counter64.sv | 34 +++
 rtl/csr_file.sv | 233 +++++++++++++++++++++++
 tb/tb_csr_file.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/csr_pkg.sv
// Shared constants and types for the machine-mode CSR file.
package csr_pkg;

  localparam int unsigned CSR_AW     = 12;
  localparam int unsigned CAUSE_W    = 4;
  localparam int unsigned CNT_HALF_W = 32;
  localparam int unsigned CNT_W      = 2 * CNT_HALF_W;

  // Implemented CSR addresses
  localparam logic [CSR_AW-1:0] CSR_MSTATUS = 12'h300;
  localparam logic [CSR_AW-1:0] CSR_MIE     = 12'h304;
  localparam logic [CSR_AW-1:0] CSR_MTVEC   = 12'h305;
  localparam logic [CSR_AW-1:0] CSR_MEPC    = 12'h341;
  localparam logic [CSR_AW-1:0] CSR_MCAUSE  = 12'h342;
  localparam logic [CSR_AW-1:0] CSR_MIP     = 12'h344;
  localparam logic [CSR_AW-1:0] CSR_MCYCLE  = 12'hB00;
  localparam logic [CSR_AW-1:0] CSR_MCYCLEH = 12'hB80;

  typedef enum logic [1:0] {
    CSR_NONE  = 2'b00,
    CSR_WRITE = 2'b01,
    CSR_SET   = 2'b10,
    CSR_CLEAR = 2'b11
  } csr_op_e;

  // Bit positions inside mstatus / mie / mip
  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;
  localparam int unsigned MIE_MTIE     = 7;
  localparam int unsigned MIE_MEIE     = 11;

  // Interrupt cause codes
  localparam logic [CAUSE_W-1:0] CAUSE_MTI = 4'd7;
  localparam logic [CAUSE_W-1:0] CAUSE_MEI = 4'd11;

  typedef struct packed {
    logic               irq;
    logic [CAUSE_W-1:0] code;
  } trap_cause_t;

endpackage

// File: rtl/csr_file_if.sv
// CSR access bus between execute stage and CSR file.
interface csr_file_if #(
  parameter int unsigned XLEN = 32
);
  import csr_pkg::*;

  logic [CSR_AW-1:0] addr;
  csr_op_e           csr_op;
  logic [XLEN-1:0]   wdata;
  logic [XLEN-1:0]   rdata;
  logic              illegal;

  modport master (output addr, output csr_op, output wdata, input rdata, input illegal);
  modport slave  (input addr, input csr_op, input wdata, output rdata, output illegal);

endinterface

// File: rtl/csr_counter64.sv
// Free-running 64-bit cycle counter with per-half overwrite.
module csr_counter64
  import csr_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_lo,
  input  logic                  wr_hi,
  input  logic [CNT_HALF_W-1:0] wdata,
  output logic [CNT_W-1:0]      count_q
);

  logic [CNT_W-1:0] count_d;

  // A half write replaces that half and holds off the increment for the cycle
  always_comb begin
    count_d = count_q + CNT_W'(1);
    if (wr_lo) begin
      count_d = {count_q[CNT_W-1:CNT_HALF_W], wdata};
    end else if (wr_hi) begin
      count_d = {wdata, count_q[CNT_HALF_W-1:0]};
    end
  end

  // Counter register, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: read-modify-write, interrupt latch, trap entry and mret.
module csr_file
  import csr_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter bit              VECTORED_EN = 1'b1,
  parameter bit              MCYCLE_EN   = 1'b1,
  parameter logic [XLEN-1:0] MTVEC_RST   = XLEN'(32'h0000_0100)
) (
  input  logic               clk,
  input  logic               rst,
  csr_file_if.slave          bus,
  input  logic [XLEN-1:0]    pc,
  input  logic               instr_valid,
  input  logic               exc_valid,
  input  logic [CAUSE_W-1:0] exc_cause,
  input  logic               mret,
  input  logic               irq_timer,
  input  logic               irq_ext,
  output logic               trap_taken,
  output logic [XLEN-1:0]    trap_pc,
  output logic [XLEN-1:0]    epc
);

  localparam int unsigned BASE_W = XLEN - 2;

  // Architectural state
  logic              mst_mie_q,  mst_mie_d;
  logic              mst_mpie_q, mst_mpie_d;
  logic              mie_mtie_q, mie_mtie_d;
  logic              mie_meie_q, mie_meie_d;
  logic              mip_mtip_q, mip_mtip_d;
  logic              mip_meip_q, mip_meip_d;
  logic [BASE_W-1:0] mtvec_base_q, mtvec_base_d;
  logic              mtvec_mode_q, mtvec_mode_d;
  logic [BASE_W-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0]   mcause_q, mcause_d;

  logic [CNT_W-1:0]  cycle_cnt;
  logic              cnt_wr_lo_c, cnt_wr_hi_c;

  logic              access_c, hit_c, csr_we_c, mret_do_c;
  logic              int_ext_c, int_tmr_c, int_pend_c;
  logic [XLEN-1:0]   old_c, new_c;
  trap_cause_t       cause_c;

  logic              unused_pc_lsb;
  assign unused_pc_lsb = ^pc[1:0];

  // Old-value read mux and address decode
  always_comb begin
    hit_c = 1'b0;
    old_c = '0;
    case (bus.addr)
      CSR_MSTATUS: begin
        hit_c               = 1'b1;
        old_c[MSTATUS_MIE]  = mst_mie_q;
        old_c[MSTATUS_MPIE] = mst_mpie_q;
      end
      CSR_MIE: begin
        hit_c           = 1'b1;
        old_c[MIE_MTIE] = mie_mtie_q;
        old_c[MIE_MEIE] = mie_meie_q;
      end
      CSR_MTVEC: begin
        hit_c = 1'b1;
        old_c = {mtvec_base_q, 1'b0, mtvec_mode_q};
      end
      CSR_MEPC: begin
        hit_c = 1'b1;
        old_c = {mepc_q, 2'b00};
      end
      CSR_MCAUSE: begin
        hit_c = 1'b1;
        old_c = mcause_q;
      end
      CSR_MIP: begin
        hit_c           = 1'b1;
        old_c[MIE_MTIE] = mip_mtip_q;
        old_c[MIE_MEIE] = mip_meip_q;
      end
      CSR_MCYCLE: begin
        hit_c = MCYCLE_EN;
        old_c = XLEN'(cycle_cnt[CNT_HALF_W-1:0]);
      end
      CSR_MCYCLEH: begin
        hit_c = MCYCLE_EN;
        old_c = XLEN'(cycle_cnt[CNT_W-1:CNT_HALF_W]);
      end
      default: begin
        hit_c = 1'b0;
        old_c = '0;
      end
    endcase
  end

  assign access_c    = (bus.csr_op != CSR_NONE);
  assign bus.illegal = access_c & ~hit_c;
  assign bus.rdata   = (access_c & hit_c) ? old_c : '0;

  // Write/set/clear value computed from the pre-write CSR contents
  always_comb begin
    new_c = bus.wdata;
    case (bus.csr_op)
      CSR_SET:   new_c = old_c | bus.wdata;
      CSR_CLEAR: new_c = old_c & ~bus.wdata;
      default:   new_c = bus.wdata;
    endcase
  end

  // Trap request, cause priority and redirect target
  always_comb begin
    int_ext_c  = mie_meie_q & mip_meip_q;
    int_tmr_c  = mie_mtie_q & mip_mtip_q;
    int_pend_c = mst_mie_q & (int_ext_c | int_tmr_c);
    trap_taken = instr_valid & (exc_valid | int_pend_c);
    mret_do_c  = instr_valid & mret & ~trap_taken;

    if (exc_valid) begin
      cause_c = '{irq: 1'b0, code: exc_cause};
    end else if (int_ext_c) begin
      cause_c = '{irq: 1'b1, code: CAUSE_MEI};
    end else begin
      cause_c = '{irq: 1'b1, code: CAUSE_MTI};
    end

    trap_pc = {mtvec_base_q, 2'b00};
    if (mtvec_mode_q && cause_c.irq) begin
      trap_pc = {mtvec_base_q, 2'b00} + (XLEN'(cause_c.code) << 2);
    end
  end

  // Read-only-access forms (set/clear with zero operand) never write
  assign csr_we_c = access_c & hit_c & ~trap_taken &
                    ~(((bus.csr_op == CSR_SET) || (bus.csr_op == CSR_CLEAR)) &&
                      (bus.wdata == '0));

  assign cnt_wr_lo_c = csr_we_c & (bus.addr == CSR_MCYCLE);
  assign cnt_wr_hi_c = csr_we_c & (bus.addr == CSR_MCYCLEH);

  assign epc = {mepc_q, 2'b00};

  // Next state: trap beats mret, mret beats an mstatus write
  always_comb begin
    mst_mie_d    = mst_mie_q;
    mst_mpie_d   = mst_mpie_q;
    mie_mtie_d   = mie_mtie_q;
    mie_meie_d   = mie_meie_q;
    mip_mtip_d   = irq_timer;
    mip_meip_d   = irq_ext;
    mtvec_base_d = mtvec_base_q;
    mtvec_mode_d = mtvec_mode_q;
    mepc_d       = mepc_q;
    mcause_d     = mcause_q;

    if (trap_taken) begin
      mepc_d                = pc[XLEN-1:2];
      mcause_d              = '0;
      mcause_d[XLEN-1]      = cause_c.irq;
      mcause_d[CAUSE_W-1:0] = cause_c.code;
      mst_mpie_d            = mst_mie_q;
      mst_mie_d             = 1'b0;
    end else begin
      if (csr_we_c) begin
        case (bus.addr)
          CSR_MSTATUS: begin
            mst_mie_d  = new_c[MSTATUS_MIE];
            mst_mpie_d = new_c[MSTATUS_MPIE];
          end
          CSR_MIE: begin
            mie_mtie_d = new_c[MIE_MTIE];
            mie_meie_d = new_c[MIE_MEIE];
          end
          CSR_MTVEC: begin
            mtvec_base_d = new_c[XLEN-1:2];
            mtvec_mode_d = VECTORED_EN & new_c[0];
          end
          CSR_MEPC:   mepc_d   = new_c[XLEN-1:2];
          CSR_MCAUSE: mcause_d = new_c;
          default:    ;
        endcase
      end
      if (mret_do_c) begin
        mst_mie_d  = mst_mpie_q;
        mst_mpie_d = 1'b1;
      end
    end
  end

  // State registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      mst_mie_q    <= 1'b0;
      mst_mpie_q   <= 1'b0;
      mie_mtie_q   <= 1'b0;
      mie_meie_q   <= 1'b0;
      mip_mtip_q   <= 1'b0;
      mip_meip_q   <= 1'b0;
      mtvec_base_q <= MTVEC_RST[XLEN-1:2];
      mtvec_mode_q <= VECTORED_EN & MTVEC_RST[0];
      mepc_q       <= '0;
      mcause_q     <= '0;
    end else begin
      mst_mie_q    <= mst_mie_d;
      mst_mpie_q   <= mst_mpie_d;
      mie_mtie_q   <= mie_mtie_d;
      mie_meie_q   <= mie_meie_d;
      mip_mtip_q   <= mip_mtip_d;
      mip_meip_q   <= mip_meip_d;
      mtvec_base_q <= mtvec_base_d;
      mtvec_mode_q <= mtvec_mode_d;
      mepc_q       <= mepc_d;
      mcause_q     <= mcause_d;
    end
  end

  // Optional 64-bit cycle counter
  generate
    if (MCYCLE_EN) begin : g_mcycle
      csr_counter64 u_counter (
        .clk     (clk),
        .rst     (rst),
        .wr_lo   (cnt_wr_lo_c),
        .wr_hi   (cnt_wr_hi_c),
        .wdata   (CNT_HALF_W'(new_c)),
        .count_q (cycle_cnt)
      );
    end else begin : g_no_mcycle
      assign cycle_cnt = '0;
    end
  endgenerate

endmodule

// File: tb/tb_csr_file.sv
// Scoreboard bench for csr_file: driver queues expectations, negedge monitor checks them.
module tb_csr_file;
  import csr_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        instr_valid, exc_valid, mret, irq_timer, irq_ext;
  logic [3:0]  exc_cause;
  logic        trap_taken;
  logic [31:0] trap_pc, epc;

  csr_file_if #(.XLEN(32)) bus ();

  csr_file #(
    .XLEN(32), .VECTORED_EN(1'b1), .MCYCLE_EN(1'b1), .MTVEC_RST(32'h0000_0100)
  ) u_dut (
    .clk(clk), .rst(rst), .bus(bus), .pc(pc), .instr_valid(instr_valid),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .mret(mret),
    .irq_timer(irq_timer), .irq_ext(irq_ext), .trap_taken(trap_taken),
    .trap_pc(trap_pc), .epc(epc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    bit          crd;
    logic [31:0] rd;
    bit          ill;
    bit          ctr;
    bit          tr;
    logic [31:0] tpc;
    bit          cep;
    logic [31:0] ep;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic cmp(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s actual=0x%08h expected=0x%08h", nm, fld, act, exp);
    end
  endtask

  // Monitor: one expectation per driven cycle, compared mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      cmp(e.nm, "illegal", 32'(bus.illegal), 32'(e.ill));
      if (e.crd) cmp(e.nm, "rdata", bus.rdata, e.rd);
      if (e.ctr) begin
        cmp(e.nm, "trap_taken", 32'(trap_taken), 32'(e.tr));
        if (e.tr) cmp(e.nm, "trap_pc", trap_pc, e.tpc);
      end
      if (e.cep) cmp(e.nm, "epc", epc, e.ep);
    end
  end

  task automatic clr();
    bus.addr    = '0;
    bus.csr_op  = CSR_NONE;
    bus.wdata   = '0;
    pc          = '0;
    instr_valid = 1'b0;
    exc_valid   = 1'b0;
    exc_cause   = '0;
    mret        = 1'b0;
    irq_timer   = 1'b0;
    irq_ext     = 1'b0;
  endtask

  task automatic csr(input logic [11:0] a, input csr_op_e op, input logic [31:0] w);
    bus.addr   = a;
    bus.csr_op = op;
    bus.wdata  = w;
  endtask

  // Queue the expectation for the current cycle, then advance one clock
  task automatic step(input string nm, input bit crd, input logic [31:0] rd,
                      input bit ill = 1'b0, input bit ctr = 1'b0, input bit tr = 1'b0,
                      input logic [31:0] tpc = 32'h0, input bit cep = 1'b0,
                      input logic [31:0] ep = 32'h0);
    exp_t e;
    e.nm = nm; e.crd = crd; e.rd = rd; e.ill = ill; e.ctr = ctr;
    e.tr = tr; e.tpc = tpc; e.cep = cep; e.ep = ep;
    q.push_back(e);
    @(posedge clk);
    #1;
    clr();
  endtask

  initial begin
    repeat (5000) @(posedge clk);
    $display("FAIL watchdog cycle budget exhausted actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    clr();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    step("rst_out", 1, 32'h0, 0, 1, 0, 32'h0, 1, 32'h0);

    // Basic read-modify-write
    csr(CSR_MTVEC, CSR_SET, 0);             step("mtvec_rst", 1, 32'h100);
    csr(CSR_MSTATUS, CSR_WRITE, 32'h8);     step("wr_mstatus", 1, 32'h0);
    csr(CSR_MIE, CSR_SET, 32'h80);          step("set_mie", 1, 32'h0);
    csr(CSR_MSTATUS, CSR_SET, 0);           step("rd_mstatus", 1, 32'h8);
    csr(CSR_MIE, CSR_SET, 0);               step("rd_mie", 1, 32'h80);
    csr(CSR_MSTATUS, CSR_CLEAR, 32'h8);     step("clr_mstatus", 1, 32'h8);
    csr(CSR_MSTATUS, CSR_SET, 0);           step("rd_mstatus0", 1, 32'h0);

    // Illegal access and read-only mip
    csr(12'h7C0, CSR_WRITE, 32'hFFFF);      step("ill_write", 1, 32'h0, 1);
    csr(12'h7C0, CSR_NONE, 32'hFFFF);       step("ill_none", 1, 32'h0, 0);
    csr(CSR_MIP, CSR_WRITE, 32'hFFFF_FFFF); step("wr_mip", 1, 32'h0);
    csr(CSR_MIP, CSR_SET, 0);               step("rd_mip", 1, 32'h0);

    // Vectored timer interrupt
    csr(CSR_MTVEC, CSR_WRITE, 32'h201);     step("wr_mtvec", 1, 32'h100);
    csr(CSR_MTVEC, CSR_SET, 0);             step("rd_mtvec", 1, 32'h201);
    csr(CSR_MSTATUS, CSR_WRITE, 32'hFFFF_FFFF); step("wr_mstatus_all", 1, 32'h0);
    csr(CSR_MSTATUS, CSR_SET, 0);           step("rd_mstatus_mask", 1, 32'h88);
    csr(CSR_MSTATUS, CSR_CLEAR, 32'h80);    step("clr_mpie", 1, 32'h88);
    irq_timer = 1'b1;                       step("tmr_raise", 0, 32'h0, 0, 1, 0);
    instr_valid = 1'b1; pc = 32'h40;
    csr(CSR_MEPC, CSR_WRITE, 32'h1234);
    step("tmr_trap", 1, 32'h0, 0, 1, 1, 32'h21C, 1, 32'h0);
    csr(CSR_MCAUSE, CSR_SET, 0);
    step("mcause_tmr", 1, 32'h8000_0007, 0, 1, 0, 32'h0, 1, 32'h40);
    csr(CSR_MSTATUS, CSR_SET, 0);           step("mstatus_tmr", 1, 32'h80);
    csr(CSR_MEPC, CSR_SET, 0);              step("mepc_tmr", 1, 32'h40);

    // Exception with external interrupt pending
    csr(CSR_MIE, CSR_SET, 32'h800); irq_ext = 1'b1; step("set_meie", 1, 32'h80);
    csr(CSR_MSTATUS, CSR_SET, 32'h8); irq_ext = 1'b1; step("set_mie_bit", 1, 32'h80);
    instr_valid = 1'b1; exc_valid = 1'b1; exc_cause = 4'd2; pc = 32'h80;
    step("exc_trap", 0, 32'h0, 0, 1, 1, 32'h200, 1, 32'h40);
    csr(CSR_MCAUSE, CSR_SET, 0);
    step("mcause_exc", 1, 32'h2, 0, 0, 0, 32'h0, 1, 32'h80);
    csr(CSR_MSTATUS, CSR_SET, 0);           step("mstatus_exc", 1, 32'h80);

    // mret, including a competing mstatus write
    instr_valid = 1'b1; mret = 1'b1; csr(CSR_MSTATUS, CSR_CLEAR, 32'h80);
    step("mret_csr", 1, 32'h80, 0, 1, 0, 32'h0, 1, 32'h80);
    csr(CSR_MSTATUS, CSR_SET, 0);
    step("mstatus_mret", 1, 32'h88, 0, 0, 0, 32'h0, 1, 32'h80);

    // mret together with an exception: trap only
    instr_valid = 1'b1; mret = 1'b1; exc_valid = 1'b1; exc_cause = 4'd3; pc = 32'h90;
    step("mret_exc", 0, 32'h0, 0, 1, 1, 32'h200, 1, 32'h80);
    csr(CSR_MSTATUS, CSR_SET, 0);
    step("mstatus_mret_exc", 1, 32'h80, 0, 0, 0, 32'h0, 1, 32'h90);
    csr(CSR_MCAUSE, CSR_SET, 0);            step("mcause_mret_exc", 1, 32'h3);

    // External beats timer, vectored
    csr(CSR_MSTATUS, CSR_SET, 32'h8); irq_ext = 1'b1; irq_timer = 1'b1;
    step("arm_both", 1, 32'h80);
    instr_valid = 1'b1; pc = 32'hA0;
    step("ext_trap", 0, 32'h0, 0, 1, 1, 32'h22C, 1, 32'h90);
    csr(CSR_MCAUSE, CSR_SET, 0);
    step("mcause_ext", 1, 32'h8000_000B, 0, 0, 0, 32'h0, 1, 32'hA0);

    // mepc low bits read as zero
    csr(CSR_MEPC, CSR_WRITE, 32'h1237);     step("wr_mepc", 1, 32'hA0);
    csr(CSR_MEPC, CSR_SET, 0);
    step("rd_mepc", 1, 32'h1234, 0, 0, 0, 32'h0, 1, 32'h1234);

    // mcycle carry across halves
    csr(CSR_MCYCLE, CSR_WRITE, 32'hFFFF_FFFF); step("wr_mcycle", 0, 32'h0);
    csr(CSR_MCYCLEH, CSR_WRITE, 32'h0);     step("wr_mcycleh", 1, 32'h0);
    step("cnt_idle", 0, 32'h0);
    csr(CSR_MCYCLE, CSR_SET, 0);            step("mcycle_wrap", 1, 32'h0);
    csr(CSR_MCYCLEH, CSR_SET, 0);           step("mcycleh_carry", 1, 32'h1);
    csr(CSR_MCYCLE, CSR_SET, 0);            step("mcycle_run", 1, 32'h2);

    // Reset mid-count, with a trap and a write presented at the same edge
    rst = 1'b0; instr_valid = 1'b1; exc_valid = 1'b1; pc = 32'h44;
    csr(CSR_MSTATUS, CSR_WRITE, 32'h8);
    step("rst_mid", 0, 32'h0);
    rst = 1'b1;
    csr(CSR_MCYCLE, CSR_SET, 0);
    step("rst_mcycle", 1, 32'h0, 0, 1, 0, 32'h0, 1, 32'h0);
    csr(CSR_MTVEC, CSR_SET, 0);             step("rst_mtvec", 1, 32'h100);
    csr(CSR_MCYCLEH, CSR_SET, 0);           step("rst_mcycleh", 1, 32'h0);
    csr(CSR_MSTATUS, CSR_SET, 0);           step("rst_mstatus", 1, 32'h0);

    @(negedge clk);
    #1;
    cmp("drain", "queue_left", 32'(q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
